word_fifo: RTL and testbench
============================

# word_fifo

Parameterized synchronous FIFO that buffers n-bit data words between a producer and the n-bit pipeline register stage it feeds. Writes and reads share one clock. Status flags let the producer and consumer throttle themselves. Out-of-range requests are ignored and flagged with one-cycle error pulses.

## Interface
- n, default 8: data word width in bits; must match the downstream register's n.
- DEPTH, default 8: number of storage entries; must be a power of two and at least 2.
- AW, derived as $clog2(DEPTH): pointer width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; rst=0 forces reset state immediately.
- wr_en  input  1  write request.
- din  input  n  write data; sampled on the same edge as wr_en.
- rd_en  input  1  read request.
- dout  output  n  read data, registered.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  AW+1  number of stored words, range 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is rejected.
- underflow  output  1  one-cycle pulse when a read is rejected.

## Operation
- Storage: DEPTH x n memory array.
  - wr_ptr and rd_ptr are AW bits wide and wrap from DEPTH-1 to 0 naturally.
  - The memory array itself is not reset.
- Reset state (rst=0): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, dout=0, overflow=0, underflow=0.
- Write acceptance: a write is accepted when wr_en=1 and either (a) full=0, or (b) full=1 and rd_en=1. Case (b) is a simultaneous read and write on a full FIFO.
  - An accepted write stores din at mem[wr_ptr] and increments wr_ptr.
- Read acceptance: a read is accepted when rd_en=1 and empty=0.
  - An accepted read loads dout with mem[rd_ptr] and increments rd_ptr.
- There is no fall-through. A write and a read in the same cycle on an empty FIFO: the write is accepted, the read is rejected and underflow pulses.
- count update on each edge:
  - +1 on write only
  - -1 on read only
  - unchanged when both or neither are accepted
- full and empty are decoded from the registered count, so they are valid in the same cycle as count.
- Rejected write (wr_en=1 while full=1 and rd_en=0):
  - memory, wr_ptr and count are unchanged
  - overflow=1 for exactly the next cycle
- Rejected read (rd_en=1 while empty=1):
  - rd_ptr and count are unchanged
  - dout holds its previous value
  - underflow=1 for exactly the next cycle
- dout holds its value whenever no read is accepted.
- Reset asserted mid-operation discards all contents: count returns to 0 and empty to 1 without waiting for a clock edge. The first write after rst deasserts lands at mem[0].

## Timing
- Write-to-visibility: a word written on edge k can be read on edge k+1 at the earliest. It then appears on dout after edge k+1.
- Read latency: 1 cycle. rd_en sampled high at edge k puts data on dout after edge k.
- Flag latency: full, empty and count reflect every accepted operation one edge after it.
- overflow and underflow are registered, one cycle wide, and never stick.
- Reset release: rst deasserts asynchronously. The first active edge with rst=1 may already accept a write.
- Maximum sustained throughput is one write plus one read per cycle.

## Test plan
Bench configuration: n=10, DEPTH=4.

1. Reset check: hold rst=0 for 2 cycles, then release -> empty=1, full=0, count=0, dout=0, both error pulses 0.
2. Fill and drain: write 0x001, 0x002, 0x003, 0x004 on four edges.
   - After the fourth write: full=1, count=4.
   - Then read four times -> dout = 0x001, 0x002, 0x003, 0x004 in order; after the last read empty=1, count=0.
3. Overflow: with the FIFO full of 0x011..0x014, write 0x3FF with rd_en=0.
   - overflow pulses for exactly 1 cycle, count stays 4.
   - Subsequent reads return 0x011..0x014 and never 0x3FF.
4. Underflow and empty-simultaneous: on an empty FIFO, assert rd_en=1 and wr_en=1 with din=0x155.
   - underflow pulses for 1 cycle, count=1, dout unchanged.
   - The next read returns 0x155.
5. Full-simultaneous and wrap-around: with the FIFO full of 0x021..0x024, assert wr_en=1 (din=0x025) and rd_en=1 in the same cycle.
   - dout=0x021, count stays 4, full stays 1.
   - Reads then return 0x022..0x025, which proves the pointers wrapped.
6. Async reset mid-operation: with count=3, pull rst low between clock edges.
   - count=0 and empty=1 before the next edge.
   - After release, write 0x0AA and read -> dout=0x0AA.

Source files
------------

// File: rtl/word_fifo_if.sv
// word_fifo_if: producer/consumer handshake bundle for word_fifo
// master: drives wr_en, din, rd_en; observes dout, full, empty, count, overflow, underflow
// slave:  the FIFO side of the same signals
interface word_fifo_if #(
    parameter int n = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);
    logic          wr_en;
    logic [n-1:0]  din;
    logic          rd_en;
    logic [n-1:0]  dout;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    modport master (
        output wr_en, din, rd_en,
        input  dout, full, empty, count, overflow, underflow
    );
    modport slave (
        input  wr_en, din, rd_en,
        output dout, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/word_fifo.sv
// word_fifo: synchronous DEPTH x n FIFO with registered read data, status flags and error pulses
// clk: rising-edge clock; rst: asynchronous active-low reset
// bus (slave): wr_en/din write request, rd_en read request, dout registered read data,
//              full/empty/count occupancy, overflow/underflow one-cycle rejection pulses
module word_fifo #(
    parameter int n = 8,
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    word_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [n-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          wr_ok, rd_ok;
    assign bus.full  = cnt == (AW+1)'(DEPTH);
    assign bus.empty = cnt == '0;
    assign bus.count = cnt;
    // a full FIFO still takes a write when a read frees a slot on the same edge
    assign wr_ok = bus.wr_en && (!bus.full || bus.rd_en);
    assign rd_ok = bus.rd_en && !bus.empty;
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= bus.din;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            bus.dout      <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                bus.dout <= mem[rd_ptr];
            end
            cnt           <= wr_ok && !rd_ok ? cnt + 1'b1 : rd_ok && !wr_ok ? cnt - 1'b1 : cnt;
            bus.overflow  <= bus.wr_en && !wr_ok;
            bus.underflow <= bus.rd_en && !rd_ok;
        end
endmodule

// File: tb/tb_word_fifo.sv
// tb_word_fifo: directed plus random check of word_fifo (n=10, DEPTH=4) against a queue model
module tb_word_fifo;
    localparam int N = 10;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [N-1:0] q [$];
    logic [N-1:0] m_dout = '0;
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    word_fifo_if #(.n(N), .DEPTH(D)) bus ();
    word_fifo #(.n(N), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask
    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(bus.count), q.size());
        chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == D));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
        chk({tag, ".dout"}, 32'(bus.dout), 32'(m_dout));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
    endtask
    // one clock edge: drive the request, let the edge pass, update the model, compare
    task automatic step(input string tag, input logic w, input logic [N-1:0] d, input logic r);
        bit wa, ra;
        bus.wr_en = w;
        bus.din   = d;
        bus.rd_en = r;
        @(posedge clk);
        wa = w && (q.size() < D || r);
        ra = r && q.size() > 0;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
        m_ovf = w && !wa;
        m_udf = r && !ra;
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk_all(tag);
    endtask
    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_release");
        for (int i = 1; i <= 4; i++) step("fill", 1'b1, N'(i), 1'b0);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step("fill_ovf", 1'b1, N'(32'h11 + i), 1'b0);
        step("overflow", 1'b1, 10'h3FF, 1'b0);
        step("overflow_clear", 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step("drain_ovf", 1'b0, '0, 1'b1);
        step("underflow_simul", 1'b1, 10'h155, 1'b1);
        step("read_155", 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step("fill_wrap", 1'b1, N'(32'h21 + i), 1'b0);
        step("full_simul", 1'b1, 10'h025, 1'b1);
        for (int i = 0; i < 4; i++) step("drain_wrap", 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step("fill3", 1'b1, N'(32'h31 + i), 1'b0);
        rst = 1'b0;
        q.delete();
        m_dout = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        chk_all("async_reset");
        @(posedge clk);
        #2 rst = 1'b1;
        step("post_reset_wr", 1'b1, 10'h0AA, 1'b0);
        step("post_reset_rd", 1'b0, '0, 1'b1);
        for (int i = 0; i < 300; i++)
            step("random", 1'($urandom_range(0, 99) < 55), N'($urandom), 1'($urandom_range(0, 99) < 45));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
